// File: rtl/port_uart_tx_pkg.sv
// Shared definitions for the port UART transmitter: serialiser state encoding,
// frame terminator characters and the nibble-to-ASCII conversion.
package port_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [2:0] LAST_BYTE_IDX = 3'd5;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/port_uart_tx_byte.sv
// 8N1 byte serialiser. ready is also high in the last cycle of the stop bit so
// the next byte can follow without an idle gap.
module uart_tx_byte
    import port_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (cnt == CNT_MAX);
    assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before this edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (start) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (start) begin
                            shreg <= data;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// Sends the memory output port value as "HHHH\r\n" over UART whenever it changes;
// changes arriving mid-frame coalesce to the newest value.
module port_uart_tx
    import port_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_data,
    output logic        tx,
    output logic        busy
);

    logic [15:0] port_q;
    logic [15:0] last_val;
    logic [15:0] snap;
    logic        force_send;
    logic [2:0]  byte_idx;
    logic [2:0]  next_idx;
    logic        launch;
    logic        ser_start;
    logic [7:0]  ser_data;
    logic        ser_ready;

    // NOTE: port_q is a plain pipeline stage, so it carries no reset; every
    // decision it feeds is already held off by the reset of the control state.
    always_ff @(posedge clk) begin
        port_q <= port_data;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        launch    = !busy && (force_send || (port_q != last_val));
        next_idx  = byte_idx + 3'd1;
        ser_start = launch || (busy && ser_ready && (byte_idx != LAST_BYTE_IDX));
        ser_data  = nibble_to_ascii(port_q[15:12]);
        if (!launch) begin
            unique case (next_idx)
                3'd1:    ser_data = nibble_to_ascii(snap[11:8]);
                3'd2:    ser_data = nibble_to_ascii(snap[7:4]);
                3'd3:    ser_data = nibble_to_ascii(snap[3:0]);
                3'd4:    ser_data = ASCII_CR;
                default: ser_data = ASCII_LF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            last_val   <= 16'h0000;
            snap       <= 16'h0000;
            force_send <= 1'b1;
            byte_idx   <= '0;
        end else if (launch) begin
            snap       <= port_q;
            last_val   <= port_q;
            force_send <= 1'b0;
            byte_idx   <= '0;
            busy       <= 1'b1;
        end else if (busy && ser_ready) begin
            // The serialiser is finishing a stop bit: either chain the next byte or end the frame.
            if (byte_idx == LAST_BYTE_IDX) begin
                busy <= 1'b0;
            end else begin
                byte_idx <= next_idx;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .data  (ser_data),
        .tx    (tx),
        .ready (ser_ready)
    );

endmodule

// File: tb/tb_port_uart_tx.sv
// Self-checking bench for port_uart_tx: records the tx waveform of every busy
// window and compares it with an ideal 8N1 waveform built from the frame text.
module tb_port_uart_tx;

    localparam int C         = 4;
    localparam int FRAME_CYC = 60 * C;

    typedef struct {
        logic [FRAME_CYC-1:0] wave;
        int                   len;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] port_data = 16'h0000;
    logic        tx;
    logic        busy;

    int n_cmp    = 0;
    int n_bad    = 0;
    int idle_err = 0;

    frame_t               frames_q[$];
    logic                 prev_busy = 1'b0;
    logic [FRAME_CYC-1:0] cur_wave;
    int                   cur_len = 0;
    logic [15:0]          last_sent;

    port_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .port_data (port_data),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: capture tx for every cycle busy is high; tx must idle high otherwise.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (!prev_busy) begin
                cur_wave = '1;
                cur_len  = 0;
            end
            if (cur_len < FRAME_CYC) cur_wave[cur_len] = tx;
            cur_len++;
        end else begin
            if (prev_busy) frames_q.push_back('{cur_wave, cur_len});
            if (tx !== 1'b1) idle_err++;
        end
        prev_busy = (busy === 1'b1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ascii_hex(input logic [3:0] n);
        int x;
        x = int'(n);
        return (x < 10) ? 8'(48 + x) : 8'(65 + x - 10);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [15:0] v, input int bi);
        logic [15:0] sh;
        if (bi == 4) return 8'h0D;
        if (bi == 5) return 8'h0A;
        sh = v >> (12 - 4 * bi);
        return ascii_hex(sh[3:0]);
    endfunction

    function automatic logic [FRAME_CYC-1:0] exp_wave(input logic [15:0] v);
        logic [FRAME_CYC-1:0] w;
        logic [7:0]           b;
        int                   t;
        w = '1;
        t = 0;
        for (int bi = 0; bi < 6; bi++) begin
            b = frame_byte(v, bi);
            for (int c = 0; c < C; c++) begin w[t] = 1'b0; t++; end
            for (int j = 0; j < 8; j++)
                for (int c = 0; c < C; c++) begin w[t] = b[j]; t++; end
            for (int c = 0; c < C; c++) begin w[t] = 1'b1; t++; end
        end
        return w;
    endfunction

    task automatic wait_frame(input int budget, output logic ok, output frame_t f);
        ok     = 1'b0;
        f.wave = '0;
        f.len  = 0;
        for (int i = 0; i < budget && frames_q.size() == 0; i++) @(negedge clk);
        if (frames_q.size() != 0) begin
            f  = frames_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic   ok;
        frame_t f;
        rst       = 1'b1;
        port_data = 16'h0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        rst = 1'b0;
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'h0000)) begin
            n_bad++;
            $display("FAIL frame_after_reset: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'h0000));
        end
        last_sent = 16'h0000;
    endtask

    task automatic test_change_latency();
        logic   ok;
        frame_t f;
        int     edges;
        repeat (5) @(negedge clk);
        port_data = 16'h1A2F;
        edges = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end while (tx !== 1'b0 && edges < 10);
        n_cmp++;
        if (edges != 2) begin
            n_bad++;
            $display("FAIL tx_fall_latency: %0d edges, want 2", edges);
        end
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'h1A2F)) begin
            n_bad++;
            $display("FAIL frame_1A2F: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'h1A2F));
        end
        last_sent = 16'h1A2F;
    endtask

    task automatic test_hold_idle();
        int bad_cycles;
        bad_cycles = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0 || frames_q.size() != 0) begin
            n_bad++;
            $display("FAIL hold_idle: %0d non-idle cycles, %0d frames, want 0 and 0",
                     bad_cycles, frames_q.size());
        end
    endtask

    task automatic test_coalesce();
        logic   ok;
        frame_t f;
        port_data = 16'h0001;
        repeat (30) @(negedge clk);
        port_data = 16'h1111;
        repeat (50) @(negedge clk);
        port_data = 16'hBEEF;
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'h0001)) begin
            n_bad++;
            $display("FAIL frame_0001: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'h0001));
        end
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'hBEEF)) begin
            n_bad++;
            $display("FAIL frame_BEEF: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'hBEEF));
        end
        repeat (400) @(negedge clk);
        n_cmp++;
        if (frames_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL coalesce_no_extra: %0d extra frames busy=%b, want 0 and 0",
                     frames_q.size(), busy);
        end
        last_sent = 16'hBEEF;
    endtask

    task automatic test_return_to_last();
        logic   ok;
        frame_t f;
        port_data = 16'h0005;
        repeat (20) @(negedge clk);
        port_data = 16'h0006;
        repeat (10) @(negedge clk);
        port_data = 16'h0005;
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'h0005)) begin
            n_bad++;
            $display("FAIL frame_0005: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'h0005));
        end
        repeat (400) @(negedge clk);
        n_cmp++;
        if (frames_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL return_no_frame: %0d extra frames busy=%b, want 0 and 0",
                     frames_q.size(), busy);
        end
        last_sent = 16'h0005;
    endtask

    task automatic test_reset_mid_frame();
        logic   ok;
        frame_t f;
        port_data = 16'h1234;
        for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clk);
        repeat (95) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_before_reset: busy=%b, want 1", busy);
        end
        rst       = 1'b1;
        port_data = 16'h00FF;
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        repeat (2) @(negedge clk);
        frames_q.delete();
        rst = 1'b0;
        wait_frame(FRAME_CYC + 50, ok, f);
        n_cmp++;
        if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(16'h00FF)) begin
            n_bad++;
            $display("FAIL frame_00FF: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                     ok, f.len, f.wave, FRAME_CYC, exp_wave(16'h00FF));
        end
        last_sent = 16'h00FF;
    endtask

    task automatic test_random();
        logic        ok;
        frame_t      f;
        logic [15:0] v0;
        logic [15:0] fin;
        int          k;
        for (int it = 0; it < 8; it++) begin
            v0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v0 = last_sent;
            port_data = v0;
            fin = v0;
            if (v0 != last_sent && $urandom_range(0, 1) == 1) begin
                // Burst of changes during the frame; only the final value may follow.
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) begin
                    repeat ($urandom_range(5, 30)) @(negedge clk);
                    fin = 16'($urandom);
                    if (j == k - 1 && $urandom_range(0, 2) == 0) fin = v0;
                    port_data = fin;
                end
            end
            if (v0 != last_sent) begin
                wait_frame(FRAME_CYC + 50, ok, f);
                n_cmp++;
                if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(v0)) begin
                    n_bad++;
                    $display("FAIL rand_frame_%0d: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                             it, ok, f.len, f.wave, FRAME_CYC, exp_wave(v0));
                end
                last_sent = v0;
            end
            if (fin != last_sent) begin
                wait_frame(FRAME_CYC + 50, ok, f);
                n_cmp++;
                if (!ok || f.len != FRAME_CYC || f.wave !== exp_wave(fin)) begin
                    n_bad++;
                    $display("FAIL rand_follow_%0d: ok=%b len=%0d wave=%h, want len=%0d wave=%h",
                             it, ok, f.len, f.wave, FRAME_CYC, exp_wave(fin));
                end
                last_sent = fin;
            end else begin
                repeat (300) @(negedge clk);
                n_cmp++;
                if (frames_q.size() != 0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_quiet_%0d: %0d frames busy=%b, want 0 and 0",
                             it, frames_q.size(), busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_change_latency();
        test_hold_idle();
        test_coalesce();
        test_return_to_last();
        test_reset_mid_frame();
        test_random();
        n_cmp++;
        if (idle_err != 0) begin
            n_bad++;
            $display("FAIL idle_line: %0d cycles with tx low while not busy, want 0", idle_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Downstream consumer of the memory block's 16-bit output port, alongside the 4-digit seven-segment driver.
- Serialises the port value over a UART TX line so a host terminal can log program output.
- Whenever the port value changes, sends a 6-byte ASCII frame: four uppercase hex digits, MS nibble first, then CR, LF.
- Sits in the top level on the CPU clock domain, fed directly by the memory port bus.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.

Ports:
clk  input  1  system clock, rising-edge, same clock that drives memory
rst  input  1  synchronous, active-high reset
port_data  input  16  memory output port value
tx  output  1  UART line, 8N1, idle high
busy  output  1  high while a frame is being transmitted

Behaviour:
- Input register: port_data is registered into port_q every cycle; all decisions use port_q.
- Reset (synchronous, active-high):
  - next edge: tx=1, busy=0; all counters and indices cleared; last_val=16'h0000; force=1; state=IDLE.
  - Reset mid-frame aborts the frame immediately; no partial stop-bit completion.
- States:
  - IDLE: if (port_q != last_val) or force, load snap=port_q, set last_val=port_q, clear force, byte_idx=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx==5, go IDLE; else byte_idx+1 and go START.
  - While in IDLE, tx=1.
- Byte sequence by byte_idx:
  - 0..3: hex(snap[15:12]), hex(snap[11:8]), hex(snap[7:4]), hex(snap[3:0]).
  - 4: 8'h0D. 5: 8'h0A.
  - hex mapping: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46.
- Latency: a port_data change sampled at edge k gives port_q at k+1; IDLE launches at k+2, so tx falls at edge k+2.
- busy:
  - High from the edge tx enters START of byte 0 until the edge STOP of byte 5 ends.
  - Low in IDLE.
  - No idle gap between bytes of a frame; consecutive frames are separated by at least 1 IDLE cycle.
- Frame length: exactly 60*CLKS_PER_BIT cycles of busy.
- Coalescing: port_q changes during a frame are not queued.
  - At return to IDLE, port_q is compared with last_val; only the newest value is sent.
  - Intermediate values are dropped.
  - A value that changes and returns to last_val before the frame ends causes no new frame.
- Bit counter width is $clog2(CLKS_PER_BIT); the counter wraps to 0 at CLKS_PER_BIT-1.
- snap is stable for the whole frame regardless of port_data activity.

Decomposition:
- Shared package/include holds:
  - the state encoding (IDLE/START/DATA/STOP, 2 bits);
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - the nibble-to-ASCII function.
- One sub-module, uart_tx_byte: 8N1 byte serialiser.
  - Ports: clk, rst, start, data[7:0], tx, ready.
  - Owns the START/DATA/STOP states and the baud counter.
  - start is accepted only when ready=1.
- port_uart_tx itself keeps only change detection, snap/last_val/force, and the byte_idx sequencer driving uart_tx_byte.

Test Plan (CLKS_PER_BIT=4, so frame = 240 cycles):
1. rst held 3 cycles with port_data=16'h0000, then released -> one frame of bytes 30 30 30 30 0D 0A; each bit lasts 4 cycles; busy high exactly 240 cycles.
2. After idle, port_data=16'h1A2F -> tx falls 2 edges later; bytes 31 41 32 46 0D 0A.
3. port_data held constant for 2000 cycles after a frame -> tx=1 and busy=0 throughout.
4. During a 16'h0001 frame, set port_data to 16'h1111, then 16'hBEEF -> after that frame, exactly one further frame 42 45 45 46 0D 0A; no 31 31 31 31 ever appears.
5. During a frame of 16'h0005, set 16'h0006 for 10 cycles, then back to 16'h0005 -> no second frame; busy low afterwards.
6. Assert rst during DATA of byte 2 -> next edge tx=1, busy=0. After release, with port_data=16'h00FF, a full frame 30 30 46 46 0D 0A is sent from byte 0.
